encoder25_round_ctrl: RTL and testbench
=======================================

Name: encoder25_round_ctrl

Overview:
Sequencer that wraps the combinational encoder25 block: accepts a 25-bit block, iterates it through encoder25 for ROUNDS clock cycles using one internal state register, and presents the result. Valid/ready handshakes on both sides let it sit between the block source (input buffer/testbench driver) and the downstream consumer. One encoder25 instance is shared across all rounds.

Parameters:
ROUNDS, 4, number of encoder25 applications per block; legal range 1..31.
CW, 5, round-counter width; must satisfy 2**CW > ROUNDS.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  source has a block on in_data
in_data  input  25  block to encode
in_ready  output  1  controller can accept a block this cycle
abort  input  1  synchronous cancel of the current block
out_valid  output  1  out_data holds a finished block
out_data  output  25  encoded result (state register)
out_ready  input  1  consumer takes the result this cycle
busy  output  1  high in RUN or DONE
round_idx  output  CW  index of the round being applied (0..ROUNDS-1); 0 outside RUN

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, state register=0, counter=0. in_ready=0 while rst is high. After reset: out_valid=0, out_data=0, busy=0, round_idx=0.
- FSM states: IDLE, RUN, DONE. rst has top priority, then abort, then normal transitions.
- IDLE: in_ready=1 (when rst=0). in_valid&in_ready at an edge -> state reg<=in_data, counter<=0, go RUN. in_valid=0 -> stay IDLE. in_data ignored without handshake.
- RUN: in_ready=0, busy=1. Each edge: state reg<=encoder25(state reg), counter<=counter+1. On the edge where counter==ROUNDS-1, go DONE; counter then reads 0.
- DONE: out_valid=1, out_data=state reg, held stable until out_valid&out_ready at an edge -> go IDLE, out_valid drops next cycle. out_data keeps its last value in IDLE (not cleared).
- Latency: accept at edge k -> out_valid first high in the cycle after edge k+ROUNDS. Minimum occupancy per block: ROUNDS+2 edges (accept, ROUNDS rounds, drain). A new block cannot be accepted in the drain cycle.
- ROUNDS=1: RUN lasts exactly one edge.
- abort=1 at an edge in any state -> IDLE, counter=0, out_valid=0 next cycle; state reg unchanged. abort during IDLE with in_valid=1 -> no accept (abort wins).
- out_ready while not in DONE: ignored. in_valid while not in IDLE: ignored; source must hold it.
- Counter never wraps: it saturates by construction at ROUNDS-1 before leaving RUN.
- rst mid-RUN or mid-DONE: block discarded, outputs return to reset values next cycle.
- No combinational path from in_valid/out_ready to in_ready/out_valid; both are decoded from the registered state (and rst for in_ready).

Test Plan:
- Reset then single block: ROUNDS=4, in_data=25'b1111001001001110100010111, out_ready=1 -> out_valid high exactly 4 cycles after acceptance edge for one cycle; out_data equals golden model encoder25 applied 4 times; round_idx steps 0,1,2,3 during RUN.
- Backpressure: in_data=25'b1001111101000101010111100, out_ready=0 for 10 cycles then 1 -> out_valid and out_data held constant 10 cycles, single transfer, busy=1 throughout, then IDLE with in_ready=1.
- Back-to-back stream: six vectors (incl. 25'b1010100000000001010101111, 25'b0110101010000001100000001) with in_valid held high -> accept every ROUNDS+2 cycles, in_ready=0 during RUN/DONE, results in order, each matching model.
- ROUNDS=1 build: in_data=25'b1101101000001110011011001 -> out_data equals single encoder25 output, out_valid 1 cycle after accept.
- Abort: accept 25'b1010011110001011010100011, assert abort at round_idx=2 -> next cycle IDLE, out_valid never asserts, in_ready=1; next block processes correctly.
- Reset mid-operation: rst=1 for one cycle during DONE with out_ready=0 -> out_valid=0, out_data=0, busy=0, round_idx=0; in_ready=0 during rst cycle, 1 after.

Source files
------------

// File: rtl/encoder25_round_ctrl.sv
// rtl/encoder25_round_ctrl.sv - multi-round sequencer around the combinational encoder25 block

// One encoder round: rotate left by 3, fold in the block shifted down by 5, whiten with a fixed key.
module encoder25 (
    input  logic [24:0] din,
    output logic [24:0] dout
);
    localparam logic [24:0] KEY = 25'h0B5A5C3;

    assign dout = {din[21:0], din[24:22]} ^ {5'b0_0000, din[24:5]} ^ KEY;
endmodule

module encoder25_round_ctrl #(
    parameter int ROUNDS = 4,
    parameter int CW     = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [24:0]   in_data,
    output logic          in_ready,
    input  logic          abort,
    output logic          out_valid,
    output logic [24:0]   out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic [CW-1:0] round_idx
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_ROUND = CW'(ROUNDS - 1);

    state_t        state;
    logic [24:0]   block;
    logic [CW-1:0] cnt;
    logic [24:0]   enc_out;

    // The single shared round instance; it always sees the current block.
    encoder25 u_enc (
        .din  (block),
        .dout (enc_out)
    );

    // Control and datapath: reset first, then abort, then the IDLE/RUN/DONE walk.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            block <= 25'd0;
            cnt   <= '0;
        end else if (abort) begin
            // The block register is left as it was; only control returns to IDLE.
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        block <= in_data;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    block <= enc_out;
                    if (cnt == LAST_ROUND) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Handshake and status flags come only from the state register (and rst for in_ready).
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);
    assign round_idx = (state == RUN) ? cnt : '0;
    assign out_data  = block;
endmodule

// File: tb/tb_encoder25_round_ctrl.sv
// tb/tb_encoder25_round_ctrl.sv - scoreboard bench for encoder25_round_ctrl
`timescale 1ns/1ps
module tb_encoder25_round_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, abort, out_ready;
    logic [24:0] in_data;
    logic        in_ready, out_valid, busy;
    logic [24:0] out_data;
    logic [4:0]  round_idx;

    logic        in_valid1, abort1, out_ready1;
    logic [24:0] in_data1;
    logic        in_ready1, out_valid1, busy1;
    logic [24:0] out_data1;
    logic [4:0]  round_idx1;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [24:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    encoder25_round_ctrl #(.ROUNDS(4), .CW(5)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .abort(abort), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .round_idx(round_idx)
    );

    encoder25_round_ctrl #(.ROUNDS(1), .CW(5)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
        .abort(abort1), .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready1),
        .busy(busy1), .round_idx(round_idx1)
    );

    function automatic logic [24:0] enc_model(input logic [24:0] x);
        logic [24:0] k;
        logic [24:0] y;
        logic        b;
        k = 25'h0B5A5C3;
        for (int i = 0; i < 25; i++) begin
            b = x[(i + 22) % 25];
            if (i < 20) b = b ^ x[i + 5];
            y[i] = b ^ k[i];
        end
        return y;
    endfunction

    function automatic logic [24:0] enc_n(input logic [24:0] x, input int n);
        logic [24:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = enc_model(y);
        return y;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every output transfer pops the oldest expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got %0h expected no transfer", out_data);
            end else begin
                check("result", {7'd0, out_data}, {7'd0, exp_q.pop_front()});
            end
        end
    end

    // Offer a block and return at posedge+1 after the accepting edge.
    task automatic send(input logic [24:0] d, input bit track, input bit hold, output int acc);
        int n;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        acc = -1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        acc = cyc;
        if (track) exp_q.push_back(enc_n(d, 4));
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        for (int n = 0; n <= 50; n++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        tests++;
        fails++;
        $display("FAIL valid_timeout: got out_valid=0 expected 1 within 50 cycles");
    endtask

    task automatic drain();
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [24:0] stream [6];
        logic [24:0] held;
        int acc, prev;

        stream[0] = 25'b1010100000000001010101111;
        stream[1] = 25'b0110101010000001100000001;
        stream[2] = 25'h0000000;
        stream[3] = 25'h1FFFFFF;
        stream[4] = 25'h0123456;
        stream[5] = 25'h1555555;

        rst = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0; in_data = '0;
        in_valid1 = 1'b0; abort1 = 1'b0; out_ready1 = 1'b1; in_data1 = '0;

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_round_idx", round_idx, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Single block, latency and round index walk
        out_ready = 1'b1;
        send(25'b1111001001001110100010111, 1, 0, acc);
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            check("round_idx", round_idx, r);
            check("run_busy", busy, 1);
            check("run_in_ready", in_ready, 0);
        end
        @(negedge clk);
        check("latency_valid", out_valid, 1);
        check("latency_cycles", cyc - acc, 4);
        check("done_round_idx", round_idx, 0);
        @(negedge clk);
        check("valid_one_cycle", out_valid, 0);
        check("back_idle", in_ready, 1);
        @(posedge clk); #1;

        // Backpressure
        out_ready = 1'b0;
        send(25'b1001111101000101010111100, 1, 0, acc);
        wait_valid();
        held = out_data;
        check("bp_value", held, enc_n(25'b1001111101000101010111100, 4));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid_hold", out_valid, 1);
            check("bp_data_hold", out_data, held);
            check("bp_busy", busy, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_after_valid", out_valid, 0);
        check("bp_after_ready", in_ready, 1);
        check("bp_after_busy", busy, 0);
        check("bp_data_kept", out_data, held);
        @(posedge clk); #1;

        // Back-to-back stream with in_valid held high
        prev = -1;
        for (int i = 0; i < 6; i++) begin
            send(stream[i], 1, (i < 5), acc);
            if (i > 0) check("stream_spacing", acc - prev, 6);
            prev = acc;
        end
        drain();

        // ROUNDS=1 build
        in_data1  = 25'b1101101000001110011011001;
        in_valid1 = 1'b1;
        @(negedge clk);
        check("r1_in_ready", in_ready1, 1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        @(negedge clk);
        check("r1_run_busy", busy1, 1);
        check("r1_run_valid", out_valid1, 0);
        @(negedge clk);
        check("r1_valid", out_valid1, 1);
        check("r1_data", out_data1, enc_model(25'b1101101000001110011011001));
        @(negedge clk);
        check("r1_valid_drop", out_valid1, 0);
        @(posedge clk); #1;

        // Abort during round 2
        send(25'b1010011110001011010100011, 0, 0, acc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_round", round_idx, 2);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_block_kept", out_data, enc_n(25'b1010011110001011010100011, 2));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_valid", out_valid, 0);
        end
        @(posedge clk); #1;
        send(25'b1111001001001110100010111, 1, 0, acc);
        drain();

        // Reset while holding a finished block
        out_ready = 1'b0;
        send(25'h0ABCDEF, 0, 0, acc);
        wait_valid();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_round_idx", round_idx, 0);
        check("midrst_in_ready_after", in_ready, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;

        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000ns");
        $fatal(1, "watchdog");
    end
endmodule
